// File: rtl/braindrop_pkg.sv
// Shared types for the braindrop mode controller: mode encoding and step helpers.
package braindrop_pkg;

  // Encoding is {mode_in0, mode_in1}, as decoded by the blinker.
  typedef enum logic [1:0] {
    OFF  = 2'b11,
    RED  = 2'b01,
    GRN  = 2'b10,
    BOTH = 2'b00
  } mode_t;

  localparam mode_t MODE_RESET = OFF;

  // Forward step: OFF -> RED -> GRN -> BOTH -> OFF.
  function automatic mode_t mode_up(input mode_t m);
    mode_t r;
    case (m)
      OFF:     r = RED;
      RED:     r = GRN;
      GRN:     r = BOTH;
      default: r = OFF;
    endcase
    return r;
  endfunction

  // Reverse step: OFF -> BOTH -> GRN -> RED -> OFF.
  function automatic mode_t mode_down(input mode_t m);
    mode_t r;
    case (m)
      OFF:     r = BOTH;
      BOTH:    r = GRN;
      GRN:     r = RED;
      default: r = OFF;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Conditions one raw active-low button: 2-flop synchroniser, stable-count
// debouncer and a one-cycle press pulse on a debounced 1->0 transition.
module btn_debounce #(
  parameter int DB_LIMIT = 250000,
  parameter int DB_CNT_W = 18
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_n,
  output logic press
);

  localparam logic [DB_CNT_W-1:0] LIMIT = DB_CNT_W'(DB_LIMIT);

  logic                sync0_reg;
  logic                sync1_reg;
  logic                db_reg;
  logic                press_reg;
  logic [DB_CNT_W-1:0] cnt_reg;

  // Bring the asynchronous button into the clock domain; idle level is released (1).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync0_reg <= 1'b1;
      sync1_reg <= 1'b1;
    end else begin
      sync0_reg <= raw_n;
      sync1_reg <= sync0_reg;
    end
  end

  // Count consecutive disagreeing samples; once the count has reached the limit, accept
  // the new level. A press pulse is emitted only when the accepted level goes 1->0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      db_reg    <= 1'b1;
      cnt_reg   <= '0;
      press_reg <= 1'b0;
    end else begin
      press_reg <= 1'b0;
      if (sync1_reg == db_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == LIMIT) begin
        db_reg    <= sync1_reg;
        cnt_reg   <= '0;
        press_reg <= db_reg;  // db_reg==1 here means the new level is 0: a press
      end else begin
        cnt_reg <= cnt_reg + DB_CNT_W'(1);
      end
    end
  end

  assign press = press_reg;

endmodule

// File: rtl/braindrop_mode_ctrl.sv
// Button-driven 4-mode sequencer feeding the blinker's IN0/IN1 level pair.
module braindrop_mode_ctrl
  import braindrop_pkg::*;
#(
  parameter int DB_LIMIT = 250000,
  parameter int DB_CNT_W = 18
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_up_n,
  input  logic btn_dn_n,
  output logic mode_in0,
  output logic mode_in1,
  output logic mode_chg
);

  // Index 0 = up button, index 1 = down button.
  logic [1:0] raw_vec;
  logic [1:0] press_vec;

  mode_t state_reg;
  mode_t state_next;
  logic  chg_reg;

  assign raw_vec = {btn_dn_n, btn_up_n};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      btn_debounce #(
        .DB_LIMIT (DB_LIMIT),
        .DB_CNT_W (DB_CNT_W)
      ) u_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .raw_n (raw_vec[gi]),
        .press (press_vec[gi])
      );
    end
  endgenerate

  // Next mode from press events; simultaneous presses force OFF.
  always_comb begin
    state_next = state_reg;
    case (press_vec)
      2'b01:   state_next = mode_up(state_reg);
      2'b10:   state_next = mode_down(state_reg);
      2'b11:   state_next = OFF;
      default: state_next = state_reg;
    endcase
  end

  // Mode register and change pulse, both visible in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= MODE_RESET;
      chg_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      chg_reg   <= (state_next != state_reg);
    end
  end

  assign mode_in0 = state_reg[1];
  assign mode_in1 = state_reg[0];
  assign mode_chg = chg_reg;

endmodule

// File: tb/tb_braindrop_mode_ctrl.sv
// Self-checking bench for braindrop_mode_ctrl with a short debounce window.
module tb_braindrop_mode_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_up_n;
  logic btn_dn_n;
  logic mode_in0;
  logic mode_in1;
  logic mode_chg;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic       up;
    logic       dn;
    logic [1:0] exp_mode;
    int         exp_chg;
  } vec_t;

  braindrop_mode_ctrl #(
    .DB_LIMIT (4),
    .DB_CNT_W (3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_up_n (btn_up_n),
    .btn_dn_n (btn_dn_n),
    .mode_in0 (mode_in0),
    .mode_in1 (mode_in1),
    .mode_chg (mode_chg)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Hold the given buttons for 'hold' cycles, release, run 'tail' cycles; count mode_chg pulses.
  task automatic run_press(input logic up, input logic dn, input int hold, input int tail,
                           output int chg_cnt);
    chg_cnt  = 0;
    btn_up_n = ~up;
    btn_dn_n = ~dn;
    for (int i = 0; i < hold; i++) begin
      step();
      chg_cnt += int'(mode_chg);
    end
    btn_up_n = 1'b1;
    btn_dn_n = 1'b1;
    for (int i = 0; i < tail; i++) begin
      step();
      chg_cnt += int'(mode_chg);
    end
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    for (int i = 0; i < cycles; i++) step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    vec_t vecs[9];
    int   chg;

    vecs[0] = '{1'b1, 1'b0, 2'b01, 1};  // OFF  -> RED
    vecs[1] = '{1'b1, 1'b0, 2'b10, 1};  // RED  -> GRN
    vecs[2] = '{1'b1, 1'b0, 2'b00, 1};  // GRN  -> BOTH
    vecs[3] = '{1'b1, 1'b0, 2'b11, 1};  // BOTH -> OFF (wrap)
    vecs[4] = '{1'b0, 1'b1, 2'b00, 1};  // OFF  -> BOTH (down wrap)
    vecs[5] = '{1'b0, 1'b1, 2'b10, 1};  // BOTH -> GRN
    vecs[6] = '{1'b1, 1'b1, 2'b11, 1};  // GRN + both -> OFF
    vecs[7] = '{1'b1, 1'b1, 2'b11, 0};  // OFF + both -> OFF, no pulse
    vecs[8] = '{1'b1, 1'b0, 2'b01, 1};  // OFF  -> RED

    // Reset: outputs defined from the first reset edge.
    rst_n    = 1'b0;
    btn_up_n = 1'b1;
    btn_dn_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("reset_mode_c%0d", i), {30'd0, mode_in0, mode_in1}, 32'h3);
      chk($sformatf("reset_chg_c%0d", i), {31'd0, mode_chg}, 32'h0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step();
    $display("reset: mode=%b%b chg=%b", mode_in0, mode_in1, mode_chg);

    // Clean up press: exact latency of 7 edges after the first sampling edge.
    chg = 0;
    btn_up_n = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k < 8) chg += int'(mode_chg);
      if (k == 7) chk("lat_before_mode", {30'd0, mode_in0, mode_in1}, 32'h3);
      if (k == 8) begin
        chk("lat_edge_mode", {30'd0, mode_in0, mode_in1}, 32'h1);
        chk("lat_edge_chg", {31'd0, mode_chg}, 32'h1);
      end
      if (k == 9) chk("lat_chg_one_cycle", {31'd0, mode_chg}, 32'h0);
    end
    chk("lat_no_early_chg", chg, 0);
    btn_up_n = 1'b1;
    chg = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      chg += int'(mode_chg);
    end
    chk("release_no_chg", chg, 0);
    chk("release_mode", {30'd0, mode_in0, mode_in1}, 32'h1);
    $display("latency press: mode=%b%b", mode_in0, mode_in1);

    // Glitch of 3 cycles is rejected.
    do_reset(2);
    run_press(1'b1, 1'b0, 3, 20, chg);
    chk("glitch_chg", chg, 0);
    chk("glitch_mode", {30'd0, mode_in0, mode_in1}, 32'h3);
    $display("glitch: mode=%b%b chg_pulses=%0d", mode_in0, mode_in1, chg);

    // Table-driven sequencing.
    for (int v = 0; v < 9; v++) begin
      run_press(vecs[v].up, vecs[v].dn, 8, 12, chg);
      chk($sformatf("vec%0d_mode", v), {30'd0, mode_in0, mode_in1}, {30'd0, vecs[v].exp_mode});
      chk($sformatf("vec%0d_chg", v), chg, vecs[v].exp_chg);
      $display("vec %0d: up=%b dn=%b mode=%b%b chg_pulses=%0d", v, vecs[v].up, vecs[v].dn,
               mode_in0, mode_in1, chg);
    end

    // Reset mid-debounce on the down button: back to OFF, no late event.
    btn_dn_n = 1'b0;
    for (int i = 0; i < 5; i++) step();
    rst_n = 1'b0;
    step();
    chk("midrst_mode", {30'd0, mode_in0, mode_in1}, 32'h3);
    chk("midrst_chg", {31'd0, mode_chg}, 32'h0);
    rst_n    = 1'b1;
    btn_dn_n = 1'b1;
    chg = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      chg += int'(mode_chg);
    end
    chk("midrst_after_chg", chg, 0);
    chk("midrst_after_mode", {30'd0, mode_in0, mode_in1}, 32'h3);
    $display("mid-debounce reset: mode=%b%b chg_pulses=%0d", mode_in0, mode_in1, chg);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
